stats_pcie_tlp_multi: RTL and testbench

Multi-segment PCIe TLP statistics monitor. It decodes the header of every segment that starts a TLP in a cycle and sums the per-segment events and DW counts into per-cycle totals. It also tracks SOP/EOP framing across segments and cycles, and counts framing violations. It sits passively on a segmented TLP interface (RX or TX) and feeds the stats counter collection logic.

---
 rtl/stats_pcie_tlp_multi.sv | 214 +++++++++++++++++++++
 tb/tb_stats_pcie_tlp_multi.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/stats_pcie_tlp_multi.sv
// Multi-segment PCIe TLP statistics monitor: per-segment header decode plus
// SOP/EOP framing tracking, summed into per-cycle event and DW totals.
package stats_pcie_tlp_multi_pkg;
  typedef struct packed {
    logic        mem_rd, mem_wr, io, cfg, msg, cpl, cpl_ur, cpl_ca, atomic, ep, err;
    logic [2:0]  hdr_dw;
    logic [10:0] req_dw, payload_dw, cpl_dw;
  } seg_dec_t;
endpackage

module stats_pcie_tlp_seg
  import stats_pcie_tlp_multi_pkg::*;
#(
  parameter int HW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [HW-1:0] hdr,
  input  logic          hdr_seg,
  input  logic          err,
  output seg_dec_t      dec
);
  logic [2:0]  fmt;
  logic [4:0]  typ;
  logic [10:0] len;
  logic        cpl_type;
  logic        unused_hdr_bits;
  seg_dec_t    nxt;

  assign fmt      = hdr[127:125];
  assign typ      = hdr[124:120];
  assign len      = (hdr[105:96] == 10'd0) ? 11'd1024 : {1'b0, hdr[105:96]};
  assign cpl_type = (typ[4:1] == 4'b0101);
  assign unused_hdr_bits = ^{hdr[119:111], hdr[109:106], hdr[95:80], hdr[76:0]};

  always_comb begin
    nxt     = '0;
    nxt.err = err;
    if (hdr_seg) begin
      nxt.mem_rd = (fmt[2:1] == 2'b00) && (typ[4:1] == 4'b0000);
      nxt.mem_wr = (fmt[2:1] == 2'b01) && (typ == 5'b00000);
      nxt.io     = !fmt[2] && !fmt[0] && (typ == 5'b00010);
      nxt.cfg    = !fmt[2] && !fmt[0] && (typ[4:1] == 4'b0010);
      nxt.msg    = !fmt[2] &&  fmt[0] && (typ[4:3] == 2'b10);
      nxt.cpl    = !fmt[2] && !fmt[0] && cpl_type;
      nxt.cpl_ur = nxt.cpl && (hdr[79:77] == 3'b001);
      nxt.cpl_ca = nxt.cpl && (hdr[79:77] == 3'b100);
      nxt.atomic = (fmt[2:1] == 2'b01) &&
                   (typ == 5'b01100 || typ == 5'b01101 || typ == 5'b01110);
      nxt.ep     = hdr[110];
      nxt.hdr_dw = fmt[0] ? 3'd4 : 3'd3;
      // fmt[1] marks a data-carrying TLP; completions with data count separately
      if (fmt[1]) begin
        if (cpl_type) nxt.cpl_dw = len;
        else          nxt.payload_dw = len;
      end else begin
        nxt.req_dw = len;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dec <= '0;
    else     dec <= nxt;
  end
endmodule

module stats_pcie_tlp_multi
  import stats_pcie_tlp_multi_pkg::*;
#(
  parameter  int TLP_HDR_WIDTH = 128,
  parameter  int TLP_SEG_COUNT = 1,
  localparam int CNT_W         = $clog2(TLP_SEG_COUNT+1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [TLP_SEG_COUNT*TLP_HDR_WIDTH-1:0] tlp_hdr,
  input  logic [TLP_SEG_COUNT-1:0]               tlp_valid,
  input  logic [TLP_SEG_COUNT-1:0]               tlp_sop,
  input  logic [TLP_SEG_COUNT-1:0]               tlp_eop,
  output logic [CNT_W-1:0]                       stat_tlp_mem_rd,
  output logic [CNT_W-1:0]                       stat_tlp_mem_wr,
  output logic [CNT_W-1:0]                       stat_tlp_io,
  output logic [CNT_W-1:0]                       stat_tlp_cfg,
  output logic [CNT_W-1:0]                       stat_tlp_msg,
  output logic [CNT_W-1:0]                       stat_tlp_cpl,
  output logic [CNT_W-1:0]                       stat_tlp_cpl_ur,
  output logic [CNT_W-1:0]                       stat_tlp_cpl_ca,
  output logic [CNT_W-1:0]                       stat_tlp_atomic,
  output logic [CNT_W-1:0]                       stat_tlp_ep,
  output logic [CNT_W-1:0]                       stat_tlp_framing_err,
  output logic [CNT_W+2:0]                       stat_tlp_hdr_dw,
  output logic [CNT_W+10:0]                      stat_tlp_req_dw,
  output logic [CNT_W+10:0]                      stat_tlp_payload_dw,
  output logic [CNT_W+10:0]                      stat_tlp_cpl_dw
);
  localparam int N = TLP_SEG_COUNT;

  logic [N-1:0][TLP_HDR_WIDTH-1:0] s1_hdr;
  logic [N-1:0]                    s1_valid, s1_sop, s1_eop;
  logic [N-1:0]                    hdr_seg, seg_err;
  logic                            in_pkt, in_pkt_nxt, pkt;
  logic [1:0]                      vld_pipe;
  seg_dec_t [N-1:0]                dec;

  logic [10:0][CNT_W-1:0] cnt_sum;
  logic [10:0]            flags;
  logic [CNT_W+2:0]       hdr_sum;
  logic [CNT_W+10:0]      req_sum, pay_sum, cpl_sum;

  always_ff @(posedge clk) s1_hdr <= tlp_hdr;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= '0;
      s1_sop   <= '0;
      s1_eop   <= '0;
      in_pkt   <= 1'b0;
      vld_pipe <= '0;
    end else begin
      s1_valid <= tlp_valid;
      s1_sop   <= tlp_sop;
      s1_eop   <= tlp_eop;
      in_pkt   <= in_pkt_nxt;
      vld_pipe <= {vld_pipe[0], |tlp_valid};
    end
  end

  // Framing walks segments in order; pkt carries the open-packet state along
  always_comb begin
    hdr_seg = '0;
    seg_err = '0;
    pkt     = in_pkt;
    for (int i = 0; i < N; i++) begin
      if (s1_valid[i]) begin
        if (s1_sop[i]) begin
          seg_err[i] = pkt;
          hdr_seg[i] = 1'b1;
          pkt        = !s1_eop[i];
        end else if (pkt) begin
          pkt = !s1_eop[i];
        end else begin
          seg_err[i] = 1'b1;
        end
      end
    end
    in_pkt_nxt = pkt;
  end

  for (genvar i = 0; i < N; i++) begin : g_seg
    stats_pcie_tlp_seg #(.HW(TLP_HDR_WIDTH)) u_seg (
      .clk     (clk),
      .rst     (rst),
      .hdr     (s1_hdr[i]),
      .hdr_seg (hdr_seg[i]),
      .err     (seg_err[i]),
      .dec     (dec[i])
    );
  end

  always_comb begin
    cnt_sum = '0;
    flags   = '0;
    hdr_sum = '0;
    req_sum = '0;
    pay_sum = '0;
    cpl_sum = '0;
    for (int i = 0; i < N; i++) begin
      flags = {dec[i].err, dec[i].ep, dec[i].atomic, dec[i].cpl_ca, dec[i].cpl_ur,
               dec[i].cpl, dec[i].msg, dec[i].cfg, dec[i].io, dec[i].mem_wr, dec[i].mem_rd};
      for (int k = 0; k < 11; k++) cnt_sum[k] = cnt_sum[k] + CNT_W'(flags[k]);
      hdr_sum = hdr_sum + (CNT_W+3)'(dec[i].hdr_dw);
      req_sum = req_sum + (CNT_W+11)'(dec[i].req_dw);
      pay_sum = pay_sum + (CNT_W+11)'(dec[i].payload_dw);
      cpl_sum = cpl_sum + (CNT_W+11)'(dec[i].cpl_dw);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !vld_pipe[1]) begin
      stat_tlp_mem_rd      <= '0;
      stat_tlp_mem_wr      <= '0;
      stat_tlp_io          <= '0;
      stat_tlp_cfg         <= '0;
      stat_tlp_msg         <= '0;
      stat_tlp_cpl         <= '0;
      stat_tlp_cpl_ur      <= '0;
      stat_tlp_cpl_ca      <= '0;
      stat_tlp_atomic      <= '0;
      stat_tlp_ep          <= '0;
      stat_tlp_framing_err <= '0;
      stat_tlp_hdr_dw      <= '0;
      stat_tlp_req_dw      <= '0;
      stat_tlp_payload_dw  <= '0;
      stat_tlp_cpl_dw      <= '0;
    end else begin
      stat_tlp_mem_rd      <= cnt_sum[0];
      stat_tlp_mem_wr      <= cnt_sum[1];
      stat_tlp_io          <= cnt_sum[2];
      stat_tlp_cfg         <= cnt_sum[3];
      stat_tlp_msg         <= cnt_sum[4];
      stat_tlp_cpl         <= cnt_sum[5];
      stat_tlp_cpl_ur      <= cnt_sum[6];
      stat_tlp_cpl_ca      <= cnt_sum[7];
      stat_tlp_atomic      <= cnt_sum[8];
      stat_tlp_ep          <= cnt_sum[9];
      stat_tlp_framing_err <= cnt_sum[10];
      stat_tlp_hdr_dw      <= hdr_sum;
      stat_tlp_req_dw      <= req_sum;
      stat_tlp_payload_dw  <= pay_sum;
      stat_tlp_cpl_dw      <= cpl_sum;
    end
  end
endmodule

// File: tb/tb_stats_pcie_tlp_multi.sv
// Scoreboard bench for stats_pcie_tlp_multi: directed test-plan cycles followed
// by randomized segment traffic, checked against a spec-level reference model.
module tb_stats_pcie_tlp_multi;
  localparam int N  = 4;
  localparam int HW = 128;
  localparam int CW = $clog2(N+1);

  logic clk, rst;
  logic [N*HW-1:0] tlp_hdr;
  logic [N-1:0]    tlp_valid, tlp_sop, tlp_eop;
  logic [CW-1:0]   o_mem_rd, o_mem_wr, o_io, o_cfg, o_msg, o_cpl, o_cpl_ur, o_cpl_ca;
  logic [CW-1:0]   o_atomic, o_ep, o_ferr;
  logic [CW+2:0]   o_hdr_dw;
  logic [CW+10:0]  o_req, o_pay, o_cpl_dw;

  stats_pcie_tlp_multi #(.TLP_HDR_WIDTH(HW), .TLP_SEG_COUNT(N)) dut (
    .clk(clk), .rst(rst), .tlp_hdr(tlp_hdr), .tlp_valid(tlp_valid), .tlp_sop(tlp_sop),
    .tlp_eop(tlp_eop), .stat_tlp_mem_rd(o_mem_rd), .stat_tlp_mem_wr(o_mem_wr),
    .stat_tlp_io(o_io), .stat_tlp_cfg(o_cfg), .stat_tlp_msg(o_msg), .stat_tlp_cpl(o_cpl),
    .stat_tlp_cpl_ur(o_cpl_ur), .stat_tlp_cpl_ca(o_cpl_ca), .stat_tlp_atomic(o_atomic),
    .stat_tlp_ep(o_ep), .stat_tlp_framing_err(o_ferr), .stat_tlp_hdr_dw(o_hdr_dw),
    .stat_tlp_req_dw(o_req), .stat_tlp_payload_dw(o_pay), .stat_tlp_cpl_dw(o_cpl_dw)
  );

  typedef struct packed {
    int tag, mem_rd, mem_wr, io, cfg, msg, cpl, cpl_ur, cpl_ca, atomic, ep, ferr;
    int hdr_dw, req, pay, cpl_dw;
  } exp_t;

  exp_t q[$];
  exp_t dexp;
  bit   use_dir;
  bit   in_pkt_m;
  int   cyc, n_cmp, n_err;
  logic [HW-1:0] h [N];
  logic [N-1:0]  v, s, e;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [HW-1:0] mk(input logic [2:0] f, input logic [4:0] t,
                                       input logic [9:0] l, input logic [2:0] st, input logic ep);
    logic [HW-1:0] x;
    x = {$urandom, $urandom, $urandom, $urandom};
    x[127:125] = f; x[124:120] = t; x[110] = ep; x[105:96] = l; x[79:77] = st;
    return x;
  endfunction

  // Reference: framing error whenever sop disagrees with "packet is closed"
  task automatic model(input logic r, output exp_t x);
    logic [7:0] ft;
    int ln;
    x = '0;
    if (r) begin in_pkt_m = 1'b0; return; end
    for (int i = 0; i < N; i++) begin
      if (!v[i]) continue;
      if (s[i] == in_pkt_m) x.ferr += 1;
      in_pkt_m = (s[i] || in_pkt_m) ? !e[i] : 1'b0;
      if (!s[i]) continue;
      ft = h[i][127:120];
      if (ft ==? 8'b00x0000x) x.mem_rd += 1;
      if (ft ==? 8'b01x00000) x.mem_wr += 1;
      if (ft ==? 8'b0x000010) x.io += 1;
      if (ft ==? 8'b0x00010x) x.cfg += 1;
      if (ft ==? 8'b0x110xxx) x.msg += 1;
      if (ft ==? 8'b0x00101x) begin
        x.cpl += 1;
        if (h[i][79:77] == 3'b001) x.cpl_ur += 1;
        if (h[i][79:77] == 3'b100) x.cpl_ca += 1;
      end
      if ((ft ==? 8'b01x01100) || (ft ==? 8'b01x01101) || (ft ==? 8'b01x01110)) x.atomic += 1;
      x.ep += int'(h[i][110]);
      ln = (h[i][105:96] == 0) ? 1024 : int'(h[i][105:96]);
      x.hdr_dw += h[i][125] ? 4 : 3;
      if (!h[i][126]) x.req += ln;
      else if (ft[4:1] == 4'b0101) x.cpl_dw += ln;
      else x.pay += ln;
    end
  endtask

  task automatic step(input logic r);
    exp_t x, z;
    @(posedge clk); #1;
    rst = r; tlp_valid = v; tlp_sop = s; tlp_eop = e;
    for (int i = 0; i < N; i++) tlp_hdr[i*HW +: HW] = h[i];
    model(r, x);
    if (use_dir && !r) x = dexp;
    // a reset edge kills everything captured in the two preceding cycles
    if (r) for (int k = 0; k < q.size(); k++)
      if (q[k].tag >= cyc - 2) begin z = '0; z.tag = q[k].tag; q[k] = z; end
    x.tag = cyc;
    q.push_back(x);
  endtask

  task automatic clr();
    v = '0; s = '0; e = '0;
    for (int i = 0; i < N; i++) h[i] = mk(3'($urandom), 5'($urandom), 10'($urandom), 3'($urandom), 1'($urandom));
  endtask

  task automatic seg(input int i, input logic [HW-1:0] hd, input logic sp, input logic ep_);
    h[i] = hd; v[i] = 1'b1; s[i] = sp; e[i] = ep_;
  endtask

  task automatic chk(input string nm, input int t, input int act, input int ex);
    n_cmp++;
    if (act != ex) begin
      n_err++;
      $display("FAIL %s tag=%0d actual=%0d expected=%0d", nm, t, act, ex);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    while (q.size() > 0 && q[0].tag + 3 < cyc) begin
      x = q.pop_front();
      chk("lost_entry", x.tag, cyc, x.tag + 3);
    end
    if (q.size() > 0 && q[0].tag + 3 == cyc) begin
      x = q.pop_front();
      chk("mem_rd", x.tag, int'(o_mem_rd), x.mem_rd);
      chk("mem_wr", x.tag, int'(o_mem_wr), x.mem_wr);
      chk("io", x.tag, int'(o_io), x.io);
      chk("cfg", x.tag, int'(o_cfg), x.cfg);
      chk("msg", x.tag, int'(o_msg), x.msg);
      chk("cpl", x.tag, int'(o_cpl), x.cpl);
      chk("cpl_ur", x.tag, int'(o_cpl_ur), x.cpl_ur);
      chk("cpl_ca", x.tag, int'(o_cpl_ca), x.cpl_ca);
      chk("atomic", x.tag, int'(o_atomic), x.atomic);
      chk("ep", x.tag, int'(o_ep), x.ep);
      chk("framing_err", x.tag, int'(o_ferr), x.ferr);
      chk("hdr_dw", x.tag, int'(o_hdr_dw), x.hdr_dw);
      chk("req_dw", x.tag, int'(o_req), x.req);
      chk("payload_dw", x.tag, int'(o_pay), x.pay);
      chk("cpl_dw", x.tag, int'(o_cpl_dw), x.cpl_dw);
    end
  end

  task automatic rand_cycle();
    logic [2:0] f;
    logic [4:0] t;
    logic [9:0] l;
    logic [2:0] st;
    clr();
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 5))
        0: f = 3'b000; 1: f = 3'b001; 2: f = 3'b010; 3: f = 3'b011; 4: f = 3'b100;
        default: f = 3'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0: t = 5'b00000; 1: t = 5'b00001; 2: t = 5'b00010; 3: t = 5'($urandom_range(4, 5));
        4: t = 5'($urandom_range(10, 11)); 5: t = 5'($urandom_range(12, 15));
        6: t = 5'($urandom_range(16, 23));
        default: t = 5'($urandom);
      endcase
      l  = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom);
      st = ($urandom_range(0, 1) != 0) ? (($urandom_range(0, 1) != 0) ? 3'b001 : 3'b100) : 3'($urandom);
      h[i] = mk(f, t, l, st, 1'($urandom));
      v[i] = ($urandom_range(0, 3) != 0);
      s[i] = ($urandom_range(0, 9) < 4);
      e[i] = ($urandom_range(0, 1) != 0);
    end
    step($urandom_range(0, 199) == 0);
  endtask

  initial begin
    cyc = 0; n_cmp = 0; n_err = 0; use_dir = 1'b0; in_pkt_m = 1'b0;
    rst = 1'b1; tlp_hdr = '0; tlp_valid = '0; tlp_sop = '0; tlp_eop = '0;
    clr();
    repeat (4) step(1'b1);
    clr(); step(1'b0);

    use_dir = 1'b1;
    // MemRd32, len 16
    clr(); seg(0, mk(3'b000, 5'b00000, 10'h010, 3'b000, 1'b0), 1, 1);
    dexp = '0; dexp.mem_rd = 1; dexp.hdr_dw = 3; dexp.req = 16; step(1'b0);
    // MemWr64 len 1024 + CplD len 8
    clr(); seg(0, mk(3'b011, 5'b00000, 10'd0, 3'b000, 1'b0), 1, 1);
    seg(1, mk(3'b010, 5'b01010, 10'd8, 3'b000, 1'b0), 1, 1);
    dexp = '0; dexp.mem_wr = 1; dexp.cpl = 1; dexp.hdr_dw = 7; dexp.pay = 1024; dexp.cpl_dw = 8;
    step(1'b0);
    // four Cpl with statuses UR, CA, UR, SC
    clr();
    seg(0, mk(3'b000, 5'b01010, 10'd5, 3'b001, 1'b1), 1, 1);
    seg(1, mk(3'b000, 5'b01010, 10'd10, 3'b100, 1'b0), 1, 1);
    seg(2, mk(3'b000, 5'b01010, 10'd0, 3'b001, 1'b1), 1, 1);
    seg(3, mk(3'b000, 5'b01010, 10'd3, 3'b000, 1'b0), 1, 1);
    dexp = '0; dexp.cpl = 4; dexp.cpl_ur = 2; dexp.cpl_ca = 1; dexp.ep = 2; dexp.hdr_dw = 12;
    dexp.req = 1042; step(1'b0);
    // framing cycle A: sop while already open
    clr(); seg(0, mk(3'b000, 5'b00000, 10'd2, 3'b000, 1'b0), 1, 0);
    seg(1, mk(3'b010, 5'b00000, 10'd4, 3'b000, 1'b0), 1, 0);
    dexp = '0; dexp.ferr = 1; dexp.mem_rd = 1; dexp.mem_wr = 1; dexp.hdr_dw = 6; dexp.req = 2;
    dexp.pay = 4; step(1'b0);
    clr(); seg(0, mk(3'b000, 5'b00000, 10'd1, 3'b000, 1'b0), 0, 1);
    dexp = '0; step(1'b0);
    clr(); seg(0, mk(3'b000, 5'b00000, 10'd1, 3'b000, 1'b1), 0, 0);
    dexp = '0; dexp.ferr = 1; step(1'b0);
    // three-cycle packet
    clr(); seg(0, mk(3'b000, 5'b00000, 10'd7, 3'b000, 1'b0), 1, 0);
    dexp = '0; dexp.mem_rd = 1; dexp.hdr_dw = 3; dexp.req = 7; step(1'b0);
    clr(); seg(0, mk(3'b011, 5'b00000, 10'd9, 3'b000, 1'b1), 0, 0);
    dexp = '0; step(1'b0);
    clr(); seg(0, mk(3'b011, 5'b00000, 10'd9, 3'b000, 1'b1), 0, 1);
    dexp = '0; step(1'b0);
    use_dir = 1'b0;
    // reset with two TLPs in flight and a packet left open
    clr(); seg(0, mk(3'b000, 5'b00000, 10'd3, 3'b000, 1'b0), 1, 1); step(1'b0);
    clr(); seg(0, mk(3'b010, 5'b00000, 10'd5, 3'b000, 1'b0), 1, 1);
    seg(1, mk(3'b000, 5'b00000, 10'd9, 3'b000, 1'b0), 1, 0); step(1'b0);
    clr(); seg(0, mk(3'b000, 5'b00000, 10'd4, 3'b000, 1'b0), 1, 1); step(1'b1);
    clr(); step(1'b0);
    use_dir = 1'b1;
    clr(); seg(0, mk(3'b000, 5'b00000, 10'd6, 3'b000, 1'b0), 0, 0);
    dexp = '0; dexp.ferr = 1; step(1'b0);
    clr(); seg(0, mk(3'b011, 5'b10000, 10'd2, 3'b000, 1'b0), 1, 1);
    dexp = '0; dexp.msg = 1; dexp.hdr_dw = 4; dexp.pay = 2; step(1'b0);
    use_dir = 1'b0;

    repeat (2500) rand_cycle();
    clr();
    repeat (3) step(1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("drain_queue_empty", cyc, q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
